// File: rtl/shift_right_sticky.sv
// Multi-cycle logical right shifter with sticky bit: resolves one shift-amount
// bit per cycle (MSB first), so latency is a fixed LG_N+1 edges from accept.
module shift_right_sticky #(
    parameter int LG_N = 5,
    localparam int N = 1 << LG_N
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_value,
    input  logic [LG_N:0]   in_shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_value,
    output logic            out_sticky
);

    localparam int STEP_W = (LG_N > 1) ? $clog2(LG_N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [N-1:0]        val;
    logic                sticky;
    logic [LG_N-1:0]     rem;
    logic [STEP_W-1:0]   step;

    // Candidate result for each stage k: shift by 2^k, plus the OR of the bits lost.
    logic [LG_N-1:0][N-1:0] shr_k;
    logic [LG_N-1:0]        lost_k;

    for (genvar k = 0; k < LG_N; k++) begin : g_stage
        localparam int D = 1 << k;
        assign shr_k[k]  = val >> D;
        assign lost_k[k] = |val[D-1:0];
    end

    logic sat;
    assign sat = (in_shamt >= (LG_N+1)'(N));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            val    <= '0;
            sticky <= 1'b0;
            rem    <= '0;
            step   <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= SHIFT;
                        step  <= STEP_W'(LG_N - 1);
                        // Saturated shifts resolve here; the SHIFT walk then does nothing.
                        if (sat) begin
                            val    <= '0;
                            sticky <= |in_value;
                            rem    <= '0;
                        end else begin
                            val    <= in_value;
                            sticky <= 1'b0;
                            rem    <= in_shamt[LG_N-1:0];
                        end
                    end
                end
                SHIFT: begin
                    if (rem[step]) begin
                        val    <= shr_k[step];
                        sticky <= sticky | lost_k[step];
                    end
                    if (step == '0) state <= DONE;
                    else            step  <= step - STEP_W'(1);
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out_value  = val;
    assign out_sticky = sticky;

endmodule

// File: doc/shift_right_sticky.md
SHIFT_RIGHT_STICKY -- requirements
Module: shift_right_sticky

Interface
REQ-001 Parameter LG_N, default 5, log2 of datapath width; N = 1 << LG_N.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 flush  input  1  synchronous abort of any in-flight operation.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_value  input  N  operand to shift right, logical.
REQ-008 in_shamt  input  LG_N+1  shift amount, 0..N; same encoding as a leading-zero count.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_value  output  N  in_value >> min(in_shamt, N).
REQ-012 out_sticky  output  1  OR of all bits shifted out.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 Accept: in IDLE with in_valid=1 and flush=0 -> latch operand, move to SHIFT, step counter = LG_N-1.
REQ-015 Saturation at accept: in_shamt >= N -> latched value = 0, sticky = |in_value, remaining shift = 0; else latched value = in_value, sticky = 0, remaining shift = in_shamt[LG_N-1:0].
REQ-016 SHIFT: each edge processes one shamt bit, MSB first; if bit[step]=1 -> value >>= 2^step, sticky |= OR of the 2^step bits discarded.
REQ-017 SHIFT with step == 0 -> after processing, move to DONE; else step decrements.
REQ-018 Fixed latency: always exactly LG_N edges in SHIFT, independent of shamt (including 0 and saturated cases); out_valid first high after the (LG_N+1)th edge counted from the accept edge.
REQ-019 DONE: out_value/out_sticky held stable while out_valid=1 and out_ready=0.
REQ-020 DONE with out_ready=1 -> IDLE on that edge; no new request accepted in the same cycle (in_ready=0 in DONE).
REQ-021 flush=1 in any state -> IDLE on next edge; in-flight result discarded; flush has priority over accept and output handshake.
REQ-022 in_valid while in SHIFT or DONE is ignored; operand inputs only sampled on the accept edge.
REQ-023 No combinational path from in_* to out_* or from out_ready to in_ready.

Reset
REQ-024 reset=0 forces, asynchronously: state IDLE, in_ready=1, out_valid=0, out_value=0, out_sticky=0, step counter=0.
REQ-025 Reset asserted mid-SHIFT or in DONE discards the operation; no out_valid pulse follows deassertion.
REQ-026 First accept possible on the first rising edge after reset deasserts.

Verification
REQ-027 LG_N=5: in_value=0x8000_0001, in_shamt=1 -> out_value=0x4000_0000, out_sticky=1, out_valid after exactly 6 edges from accept.
REQ-028 in_value=0xF000_0000, in_shamt=0 -> out_value=0xF000_0000, out_sticky=0, same 6-edge latency.
REQ-029 in_value=0x0000_0010, in_shamt=32 -> out_value=0, out_sticky=1; in_shamt=63 (out-of-range) -> identical result.
REQ-030 in_value=0x1234_5678, in_shamt=31, out_ready held 0 for 10 cycles -> out_value=0, out_sticky=1 held stable, in_ready=0 throughout; then out_ready=1 -> IDLE next edge.
REQ-031 flush=1 on 3rd SHIFT edge -> IDLE next edge, no out_valid; reset=0 pulse mid-SHIFT -> all outputs at reset values immediately.
REQ-032 Randomized: 10k requests with random value/shamt/out_ready back-pressure vs. reference model (value >> min(shamt,N), sticky = OR of discarded bits); zero mismatches.
